cpu_run_ctrl: RTL and testbench
===============================

Name: cpu_run_ctrl

Overview:
Run/step/breakpoint sequencer for the single-cycle MIPS core. It replaces the free-running clock divider with a qualified one-cycle enable, cpu_tick, which advances the core (PC, register file, data-memory writes) by one instruction. It gives board-level control: run, halt, debounced single-step, and a hardware PC breakpoint. It also keeps a retired-instruction counter for the display.

Parameters:
width, 32, datapath/PC width
DIV, 100000000, prescaler period in clk cycles between candidate ticks (minimum 2)
DEB, 1000000, step-button stable-time in clk cycles before a level change is accepted (minimum 1)

Ports:
clk  input  1  system clock; sole clock of the block
reset  input  1  asynchronous, active-low reset
run_sw  input  1  asynchronous run switch (1 = run)
step_btn  input  1  asynchronous, bouncy single-step pushbutton (1 = pressed)
bp_en  input  1  breakpoint enable
bp_addr  input  width  breakpoint PC (byte address)
pc  input  width  current PC from the core
cpu_tick  output  1  registered one-clk-cycle enable; one instruction retires per pulse
halted  output  1  1 when state is HALT or BREAK
state  output  2  00 HALT, 01 RUN, 10 STEP, 11 BREAK
inst_cnt  output  width  count of cpu_tick pulses

Behaviour:
- Reset (reset=0, asynchronous):
  - state=HALT, cpu_tick=0, halted=1, inst_cnt=0.
  - Prescaler=0, synchronisers, debouncer and bp_skip cleared.
  - Debounced button level=0.
- Input synchronisation:
  - run_sw and step_btn each pass through a 2-FF synchroniser.
  - run_rise = synced run_sw 0->1 edge.
- Debouncer:
  - Counter reloads whenever the synced step_btn equals the accepted level.
  - When the synced level has differed from the accepted level for DEB consecutive cycles, the accepted level updates.
  - step_press = single-cycle pulse on an accepted 0->1 transition.
- Prescaler:
  - Free-runs 0..DIV-1 in every state, then wraps to 0.
  - pre = 1 in the cycle where the count is DIV-1.
- FSM (evaluated every clk):
  - HALT:
    - synced run_sw=1 -> RUN.
    - else step_press -> STEP.
  - RUN:
    - synced run_sw=0 -> HALT, no tick.
    - else on pre:
      - If bp_en, pc==bp_addr and bp_skip=0 -> BREAK, no tick.
      - Otherwise issue a tick and clear bp_skip.
  - STEP:
    - On pre, issue a tick -> HALT.
    - run_sw rising while in STEP is ignored until HALT is reached.
  - BREAK:
    - run_rise -> RUN with bp_skip=1, so the breakpointed instruction executes once.
    - else step_press -> STEP.
    - run_sw held at 1 does not resume; an edge is required.
- Tick issue:
  - cpu_tick is registered: it asserts in the cycle after the deciding cycle, for exactly 1 clk cycle.
  - Minimum spacing between ticks is DIV cycles.
  - STEP latency is 1..DIV cycles after step_press.
- inst_cnt increments by 1 in the same cycle cpu_tick is high; it wraps modulo 2^width.
- Breakpoint compare is a full width-bit equality on pc; it is sampled only on pre.
- Simultaneous events:
  - run_rise and step_press in the same cycle: run wins.
  - Breakpoint hit and run_sw=0 in the same cycle: HALT.
  - step_press while in RUN or STEP is discarded (not queued).
- Reset asserted mid-operation:
  - A pending tick is dropped.
  - After release, the first tick can occur no earlier than DIV cycles later.

Test Plan:
1. DIV=4, DEB=3. Release reset with run_sw=0, step_btn=0 for 40 cycles -> cpu_tick never high, state=00, halted=1, inst_cnt=0.
2. Set run_sw=1 -> state=01 within 3 cycles; cpu_tick pulses of width 1 exactly every 4 cycles; after 10 pulses inst_cnt=10. Drop run_sw -> state=00 with no further pulses.
3. In HALT, bounce step_btn 1,0,1,0 at 1-cycle intervals, then hold 1 for 10 cycles -> exactly one step_press, one cpu_tick, inst_cnt +1, state returns to 00.
4. Breakpoint: bp_en=1, bp_addr=0x0000000C, bench increments pc by 4 per tick from 0, run_sw=1 -> ticks at pc 0, 4, 8, then state=11, halted=1, no tick with pc=0xC.
   - Toggle run_sw 0->1 -> next tick executes pc=0xC and continues; a second pass at 0xC halts again.
5. In BREAK, press step -> exactly one tick, state=00; run_rise and step_press in the same cycle from BREAK -> state=01.
6. Assert reset low for 1 cycle while a tick is pending in RUN -> no tick, all outputs at reset values.
   - Force inst_cnt to 0xFFFFFFFF, issue one tick -> inst_cnt=0.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// Run/halt/single-step/breakpoint sequencer for the single-cycle MIPS core.
// Produces a registered one-cycle cpu_tick and counts the instructions it retires.
module cpu_run_ctrl #(
    parameter int unsigned width = 32,
    parameter int unsigned DIV   = 100000000,
    parameter int unsigned DEB   = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_sw,
    input  logic             step_btn,
    input  logic             bp_en,
    input  logic [width-1:0] bp_addr,
    input  logic [width-1:0] pc,
    output logic             cpu_tick,
    output logic             halted,
    output logic [1:0]       state,
    output logic [width-1:0] inst_cnt
);

    localparam int unsigned     PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned     DW       = (DEB > 1) ? $clog2(DEB) : 1;
    localparam logic [PW-1:0]   PRE_LAST = PW'(DIV - 1);
    localparam logic [DW-1:0]   DEB_LAST = DW'(DEB - 1);

    typedef enum logic [1:0] {
        S_HALT  = 2'b00,
        S_RUN   = 2'b01,
        S_STEP  = 2'b10,
        S_BREAK = 2'b11
    } state_t;

    logic             run_s1_q, run_s1_d, run_s2_q, run_s2_d, run_prev_q, run_prev_d;
    logic             step_s1_q, step_s1_d, step_s2_q, step_s2_d;
    logic             deb_lvl_q, deb_lvl_d, step_press_q, step_press_d;
    logic [DW-1:0]    deb_cnt_q, deb_cnt_d;
    logic [PW-1:0]    pre_cnt_q, pre_cnt_d;
    state_t           state_q, state_d;
    logic             bp_skip_q, bp_skip_d;
    logic             tick_q, tick_d;
    logic [width-1:0] inst_cnt_q, inst_cnt_d;

    logic pre, run_rise, bp_hit;

    assign pre      = (pre_cnt_q == PRE_LAST);
    assign run_rise = run_s2_q & ~run_prev_q;
    assign bp_hit   = bp_en & (pc == bp_addr);

    // Input conditioning: synchronisers, step debouncer, free-running prescaler.
    always_comb begin
        run_s1_d     = run_sw;
        run_s2_d     = run_s1_q;
        run_prev_d   = run_s2_q;
        step_s1_d    = step_btn;
        step_s2_d    = step_s1_q;
        deb_lvl_d    = deb_lvl_q;
        deb_cnt_d    = '0;
        step_press_d = 1'b0;
        if (step_s2_q != deb_lvl_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                deb_lvl_d    = step_s2_q;
                step_press_d = step_s2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DW'(1);
            end
        end
        pre_cnt_d = pre ? '0 : pre_cnt_q + PW'(1);
    end

    always_comb begin
        state_d   = state_q;
        bp_skip_d = bp_skip_q;
        tick_d    = 1'b0;
        case (state_q)
            S_HALT: begin
                if (run_s2_q)          state_d = S_RUN;
                else if (step_press_q) state_d = S_STEP;
            end
            S_RUN: begin
                if (!run_s2_q) begin
                    state_d = S_HALT;
                end else if (pre) begin
                    if (bp_hit && !bp_skip_q) begin
                        state_d = S_BREAK;
                    end else begin
                        tick_d    = 1'b1;
                        bp_skip_d = 1'b0;
                    end
                end
            end
            S_STEP: begin
                if (pre) begin
                    tick_d  = 1'b1;
                    state_d = S_HALT;
                end
            end
            S_BREAK: begin
                // bp_skip lets the breakpointed instruction retire once on resume.
                if (run_rise) begin
                    state_d   = S_RUN;
                    bp_skip_d = 1'b1;
                end else if (step_press_q) begin
                    state_d = S_STEP;
                end
            end
            default: state_d = S_HALT;
        endcase
        inst_cnt_d = tick_d ? inst_cnt_q + width'(1) : inst_cnt_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_s1_q     <= 1'b0;
            run_s2_q     <= 1'b0;
            run_prev_q   <= 1'b0;
            step_s1_q    <= 1'b0;
            step_s2_q    <= 1'b0;
            deb_lvl_q    <= 1'b0;
            deb_cnt_q    <= '0;
            step_press_q <= 1'b0;
            pre_cnt_q    <= '0;
            state_q      <= S_HALT;
            bp_skip_q    <= 1'b0;
            tick_q       <= 1'b0;
            inst_cnt_q   <= '0;
        end else begin
            run_s1_q     <= run_s1_d;
            run_s2_q     <= run_s2_d;
            run_prev_q   <= run_prev_d;
            step_s1_q    <= step_s1_d;
            step_s2_q    <= step_s2_d;
            deb_lvl_q    <= deb_lvl_d;
            deb_cnt_q    <= deb_cnt_d;
            step_press_q <= step_press_d;
            pre_cnt_q    <= pre_cnt_d;
            state_q      <= state_d;
            bp_skip_q    <= bp_skip_d;
            tick_q       <= tick_d;
            inst_cnt_q   <= inst_cnt_d;
        end
    end

    assign cpu_tick = tick_q;
    assign inst_cnt = inst_cnt_q;
    assign state    = state_q;
    assign halted   = (state_q == S_HALT) || (state_q == S_BREAK);

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: table vectors, directed corner sequences and random
// stimulus, all compared every cycle against a behavioural model.
module tb_cpu_run_ctrl;

    localparam int unsigned DIV_T = 4;
    localparam int unsigned DEB_T = 3;

    logic        clk = 1'b0;
    logic        reset, run_sw, step_btn, bp_en;
    logic [31:0] bp_addr, pc;
    logic        cpu_tick, halted;
    logic [1:0]  state;
    logic [31:0] inst_cnt;

    logic        w_run, w_tick, w_halted;
    logic [1:0]  w_state;
    logic [3:0]  w_inst;

    always #5 clk = ~clk;

    cpu_run_ctrl #(.width(32), .DIV(DIV_T), .DEB(DEB_T)) dut (
        .clk(clk), .reset(reset), .run_sw(run_sw), .step_btn(step_btn), .bp_en(bp_en),
        .bp_addr(bp_addr), .pc(pc), .cpu_tick(cpu_tick), .halted(halted),
        .state(state), .inst_cnt(inst_cnt)
    );

    // Narrow instance so the counter wrap is reachable in a few cycles.
    cpu_run_ctrl #(.width(4), .DIV(2), .DEB(1)) dut_w (
        .clk(clk), .reset(reset), .run_sw(w_run), .step_btn(1'b0), .bp_en(1'b0),
        .bp_addr(4'h0), .pc(4'h0), .cpu_tick(w_tick), .halted(w_halted),
        .state(w_state), .inst_cnt(w_inst)
    );

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: state names 0 HALT, 1 RUN, 2 STEP, 3 BREAK.
    bit          rq[$], sq[$];
    int          m_state, m_cyc, m_dcnt;
    bit          m_tick, m_skip, m_acc, m_press;
    logic [31:0] m_inst;
    logic [31:0] pc_mask = 32'hFFFF_FFFF;
    logic [31:0] last_tick_pc;

    task automatic model_reset();
        m_state = 0; m_tick = 0; m_inst = '0; m_skip = 0;
        m_cyc = 0; m_acc = 0; m_dcnt = 0; m_press = 0;
        rq = {1'b0, 1'b0, 1'b0};
        sq = {1'b0, 1'b0, 1'b0};
    endtask

    task automatic model_edge();
        bit rs, rp, sb, pre, tk, press_new;
        int ns;
        rs = rq[1]; rp = rq[0]; sb = sq[1];
        pre = ((m_cyc % DIV_T) == DIV_T - 1);
        ns = m_state; tk = 0;
        case (m_state)
            0: if (rs) ns = 1; else if (m_press) ns = 2;
            1: if (!rs) ns = 0;
               else if (pre) begin
                   if (bp_en && pc == bp_addr && !m_skip) ns = 3;
                   else begin tk = 1; m_skip = 0; end
               end
            2: if (pre) begin tk = 1; ns = 0; end
            default: if (rs && !rp) begin ns = 1; m_skip = 1; end
                     else if (m_press) ns = 2;
        endcase
        press_new = 0;
        if (sb == m_acc) m_dcnt = 0;
        else begin
            m_dcnt++;
            if (m_dcnt == DEB_T) begin m_acc = sb; m_dcnt = 0; press_new = sb; end
        end
        m_press = press_new;
        m_state = ns;
        m_tick  = tk;
        if (tk) m_inst = m_inst + 1;
        m_cyc++;
        rq.push_back(run_sw);   void'(rq.pop_front());
        sq.push_back(step_btn); void'(sq.pop_front());
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (!reset) model_reset(); else model_edge();
        @(negedge clk);
        chk("tick", {31'd0, cpu_tick}, {31'd0, m_tick});
        chk("state", {30'd0, state}, 32'(m_state));
        chk("halted", {31'd0, halted}, {31'd0, (m_state == 0 || m_state == 3)});
        chk("inst_cnt", inst_cnt, m_inst);
        if (cpu_tick) begin
            last_tick_pc = pc;
            pc = (pc + 32'd4) & pc_mask;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(); step();
        reset = 1'b1;
    endtask

    typedef struct {
        logic        run;
        logic [1:0]  st;
        logic        tick;
        logic [31:0] inst;
    } vec_t;
    vec_t tbl[16];

    int nt, last, first, cnt;

    initial begin
        tbl[0]  = '{1'b0, 2'd0, 1'b0, 32'd0};
        tbl[1]  = '{1'b0, 2'd0, 1'b0, 32'd0};
        tbl[2]  = '{1'b0, 2'd0, 1'b0, 32'd0};
        tbl[3]  = '{1'b1, 2'd0, 1'b0, 32'd0};
        tbl[4]  = '{1'b1, 2'd0, 1'b0, 32'd0};
        tbl[5]  = '{1'b1, 2'd1, 1'b0, 32'd0};
        tbl[6]  = '{1'b1, 2'd1, 1'b0, 32'd0};
        tbl[7]  = '{1'b1, 2'd1, 1'b1, 32'd1};
        tbl[8]  = '{1'b1, 2'd1, 1'b0, 32'd1};
        tbl[9]  = '{1'b1, 2'd1, 1'b0, 32'd1};
        tbl[10] = '{1'b1, 2'd1, 1'b0, 32'd1};
        tbl[11] = '{1'b1, 2'd1, 1'b1, 32'd2};
        tbl[12] = '{1'b0, 2'd1, 1'b0, 32'd2};
        tbl[13] = '{1'b0, 2'd1, 1'b0, 32'd2};
        tbl[14] = '{1'b0, 2'd0, 1'b0, 32'd2};
        tbl[15] = '{1'b0, 2'd0, 1'b0, 32'd2};

        reset = 1'b0; run_sw = 1'b0; step_btn = 1'b0; bp_en = 1'b0;
        bp_addr = 32'h0; pc = 32'h0; w_run = 1'b0; last_tick_pc = 32'h0;
        model_reset();

        // Idle after reset: nothing happens.
        do_reset();
        nt = 0;
        for (int i = 0; i < 40; i++) begin step(); if (cpu_tick) nt++; end
        chk("idle_ticks", 32'(nt), 32'd0);
        chk("idle_state", {30'd0, state}, 32'd0);
        chk("idle_inst", inst_cnt, 32'd0);

        // Table: run start latency, tick cadence, halt on run drop.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            run_sw = tbl[i].run;
            step();
            chk("tbl_state", {30'd0, state}, {30'd0, tbl[i].st});
            chk("tbl_tick", {31'd0, cpu_tick}, {31'd0, tbl[i].tick});
            chk("tbl_inst", inst_cnt, tbl[i].inst);
        end

        // Ten evenly spaced ticks, then halt with no further ticks.
        run_sw = 1'b1; nt = 0; last = 0;
        for (int c = 0; c < 80 && nt < 10; c++) begin
            step();
            if (cpu_tick) begin
                if (nt > 0) chk("run_spacing", 32'(c - last), DIV_T);
                last = c; nt++;
            end
        end
        chk("run_10_ticks", 32'(nt), 32'd10);
        chk("run_inst", inst_cnt, 32'd12);
        run_sw = 1'b0;
        for (int c = 0; c < 10 && state != 2'd0; c++) step();
        nt = 0;
        for (int i = 0; i < 12; i++) begin step(); if (cpu_tick) nt++; end
        chk("halt_no_ticks", 32'(nt), 32'd0);

        // Bouncy step button: exactly one instruction.
        nt = 0;
        for (int i = 0; i < 4; i++) begin step_btn = (i % 2 == 0); step(); if (cpu_tick) nt++; end
        step_btn = 1'b1;
        for (int i = 0; i < 10; i++) begin step(); if (cpu_tick) nt++; end
        step_btn = 1'b0;
        for (int i = 0; i < 10; i++) begin step(); if (cpu_tick) nt++; end
        chk("step_ticks", 32'(nt), 32'd1);
        chk("step_inst", inst_cnt, 32'd13);
        chk("step_state", {30'd0, state}, 32'd0);

        // Breakpoint at 0xC, resume on run edge, second pass breaks again.
        reset = 1'b0; pc = 32'h0; bp_en = 1'b1; bp_addr = 32'hC; run_sw = 1'b1;
        step(); step(); reset = 1'b1;
        nt = 0;
        for (int c = 0; c < 60 && state != 2'd3; c++) begin step(); if (cpu_tick) nt++; end
        chk("bp_ticks_before", 32'(nt), 32'd3);
        chk("bp_pc", pc, 32'hC);
        chk("bp_halted", {31'd0, halted}, 32'd1);
        chk("bp_inst", inst_cnt, 32'd3);
        run_sw = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("bp_hold_low", {30'd0, state}, 32'd3);
        run_sw = 1'b1; nt = 0;
        for (int c = 0; c < 20 && nt < 1; c++) begin step(); if (cpu_tick) nt++; end
        chk("bp_resume_pc", last_tick_pc, 32'hC);
        for (int c = 0; c < 20 && nt < 3; c++) begin step(); if (cpu_tick) nt++; end
        pc = 32'h0; nt = 0;
        for (int c = 0; c < 60 && state != 2'd3; c++) begin step(); if (cpu_tick) nt++; end
        chk("bp_second_pc", pc, 32'hC);
        chk("bp_second_ticks", 32'(nt), 32'd3);

        // Single step out of BREAK.
        run_sw = 1'b0;
        for (int i = 0; i < 4; i++) step();
        step_btn = 1'b1; nt = 0;
        for (int i = 0; i < 8; i++) begin step(); if (cpu_tick) nt++; end
        step_btn = 1'b0;
        for (int i = 0; i < 12; i++) begin step(); if (cpu_tick) nt++; end
        chk("brk_step_ticks", 32'(nt), 32'd1);
        chk("brk_step_pc", last_tick_pc, 32'hC);
        chk("brk_step_state", {30'd0, state}, 32'd0);

        // run_rise and step_press on the same edge from BREAK: run wins.
        pc = 32'hC; run_sw = 1'b1;
        for (int c = 0; c < 30 && state != 2'd3; c++) step();
        chk("sim_in_break", {30'd0, state}, 32'd3);
        run_sw = 1'b0;
        for (int i = 0; i < 5; i++) step();
        step_btn = 1'b1;
        step(); step(); step();
        run_sw = 1'b1;
        step(); step();
        chk("sim_still_break", {30'd0, state}, 32'd3);
        step();
        chk("sim_run_wins", {30'd0, state}, 32'd1);
        step_btn = 1'b0;

        // Reset just before a tick-issuing edge in RUN.
        bp_en = 1'b0;
        for (int c = 0; c < 30 && !(m_state == 1 && (m_cyc % DIV_T) == DIV_T - 1); c++) step();
        reset = 1'b0;
        #1;
        chk("rst_async_tick", {31'd0, cpu_tick}, 32'd0);
        chk("rst_async_state", {30'd0, state}, 32'd0);
        chk("rst_async_halted", {31'd0, halted}, 32'd1);
        chk("rst_async_inst", inst_cnt, 32'd0);
        step();
        reset = 1'b1;
        first = 0;
        for (int c = 1; c <= 20 && first == 0; c++) begin step(); if (cpu_tick) first = c; end
        chk("rst_first_tick_late", {31'd0, first >= int'(DIV_T)}, 32'd1);

        // Counter wrap on the narrow instance.
        w_run = 1'b1; cnt = 0;
        for (int c = 0; c < 100 && cnt < 16; c++) begin
            step();
            if (w_tick) begin
                cnt++;
                if (cnt == 15) chk("wrap_all_ones", {28'd0, w_inst}, 32'hF);
                if (cnt == 16) chk("wrap_zero", {28'd0, w_inst}, 32'h0);
            end
        end
        chk("wrap_tick_count", 32'(cnt), 32'd16);
        w_run = 1'b0;

        // Random stimulus against the model.
        pc_mask = 32'hC; pc = 32'h0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(39) == 0) run_sw = ~run_sw;
            if ($urandom_range(5) == 0) step_btn = ~step_btn;
            if ($urandom_range(49) == 0) bp_en = ~bp_en;
            if ($urandom_range(59) == 0) bp_addr = 32'($urandom_range(3)) << 2;
            if ($urandom_range(99) == 0) pc = 32'($urandom_range(3)) << 2;
            reset = ($urandom_range(299) != 0);
            step();
            reset = 1'b1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
